// File: rtl/gptimer_multi_pkg.sv
// rtl/gptimer_multi_pkg.sv - register offsets, CTL bit positions and byte-lane merge helper
package gptimer_multi_pkg;

   localparam logic [1:0] REG_CTL    = 2'd0;
   localparam logic [1:0] REG_PERIOD = 2'd1;
   localparam logic [1:0] REG_COUNT  = 2'd2;
   localparam logic [1:0] REG_DUTY   = 2'd3;

   localparam int CTL_EN           = 0;
   localparam int CTL_MODE         = 1;
   localparam int CTL_IE           = 2;
   localparam int CTL_RST          = 3;
   localparam int CTL_PEND         = 8;
   localparam int CTL_PRESCALE_LSB = 16;

   function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
      logic [31:0] res;
      res = old_val;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) res[8*b +: 8] = new_val[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/gptimer_channel.sv
// rtl/gptimer_channel.sv - one timer channel: prescaler, counter, PEND flag, PWM
// PWM and the DUTY register exist only when GPTIMER_PWM_EN is defined.
module gptimer_channel
   import gptimer_multi_pkg::*;
#(
   parameter int WIDTH          = 32,
   parameter int PRESCALE_WIDTH = 8
) (
   input  logic        clk,
   input  logic        resetq,
   input  logic        wr_en,
   input  logic [1:0]  reg_sel,
   input  logic [3:0]  wr_be,
   input  logic [31:0] wdata,
   output logic [31:0] ctl_rd,
   output logic [31:0] period_rd,
   output logic [31:0] count_rd,
   output logic [31:0] duty_rd,
   output logic        irq,
   output logic        pwm
);

   logic                      en_q, en_d, mode_q, mode_d, ie_q, ie_d, pend_q, pend_d;
   logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d, ps_q, ps_d;
   logic [WIDTH-1:0]          period_q, period_d, count_q, count_d;
   logic                      tick, terminal, pend_clr;
   logic [31:0]               merged;
`ifdef GPTIMER_PWM_EN
   logic [WIDTH-1:0]          duty_q, duty_d;
   logic                      pwm_q, pwm_d;
`endif

   always_comb begin
      tick       = en_q && (ps_q == prescale_q);
      terminal   = tick && (count_q >= period_q);
      en_d       = en_q;
      mode_d     = mode_q;
      ie_d       = ie_q;
      prescale_d = prescale_q;
      period_d   = period_q;
      pend_clr   = 1'b0;
      merged     = '0;
      ps_d       = ps_q;
      count_d    = count_q;
`ifdef GPTIMER_PWM_EN
      duty_d     = duty_q;
`endif
      if (en_q) ps_d = tick ? '0 : ps_q + PRESCALE_WIDTH'(1);
      if (tick) count_d = terminal ? '0 : count_q + WIDTH'(1);
      if (terminal && mode_q) en_d = 1'b0;
      // Software writes are applied last so they win over the tick update.
      if (wr_en) begin
         case (reg_sel)
            REG_CTL: begin
               if (wr_be[0]) begin
                  en_d   = wdata[CTL_EN];
                  mode_d = wdata[CTL_MODE];
                  ie_d   = wdata[CTL_IE];
                  if (wdata[CTL_RST]) begin
                     count_d = '0;
                     ps_d    = '0;
                  end
               end
               if (wr_be[1]) pend_clr = wdata[CTL_PEND];
               if (wr_be[2]) prescale_d = wdata[CTL_PRESCALE_LSB +: PRESCALE_WIDTH];
            end
            REG_PERIOD: begin
               merged   = byte_merge(32'(period_q), wdata, wr_be);
               period_d = merged[WIDTH-1:0];
            end
            REG_COUNT: begin
               merged  = byte_merge(32'(count_q), wdata, wr_be);
               count_d = merged[WIDTH-1:0];
            end
            default: begin
`ifdef GPTIMER_PWM_EN
               merged = byte_merge(32'(duty_q), wdata, wr_be);
               duty_d = merged[WIDTH-1:0];
`endif
            end
         endcase
      end
      // A hardware terminal tick overrides a same-cycle W1C.
      pend_d = (pend_q && !pend_clr) || terminal;
`ifdef GPTIMER_PWM_EN
      pwm_d  = en_d && (count_d < duty_d);
`endif
   end

   always_ff @(posedge clk) begin
      if (!resetq) begin
         en_q       <= 1'b0;
         mode_q     <= 1'b0;
         ie_q       <= 1'b0;
         pend_q     <= 1'b0;
         prescale_q <= '0;
         ps_q       <= '0;
         period_q   <= '1;
         count_q    <= '0;
      end else begin
         en_q       <= en_d;
         mode_q     <= mode_d;
         ie_q       <= ie_d;
         pend_q     <= pend_d;
         prescale_q <= prescale_d;
         ps_q       <= ps_d;
         period_q   <= period_d;
         count_q    <= count_d;
      end
   end

`ifdef GPTIMER_PWM_EN
   always_ff @(posedge clk) begin
      if (!resetq) begin
         duty_q <= '0;
         pwm_q  <= 1'b0;
      end else begin
         duty_q <= duty_d;
         pwm_q  <= pwm_d;
      end
   end
   assign duty_rd = 32'(duty_q);
   assign pwm     = pwm_q;
`else
   assign duty_rd = '0;
   assign pwm     = 1'b0;
`endif

   always_comb begin
      ctl_rd                                         = '0;
      ctl_rd[CTL_EN]                                 = en_q;
      ctl_rd[CTL_MODE]                               = mode_q;
      ctl_rd[CTL_IE]                                 = ie_q;
      ctl_rd[CTL_PEND]                               = pend_q;
      ctl_rd[CTL_PRESCALE_LSB +: PRESCALE_WIDTH]     = prescale_q;
   end

   assign period_rd = 32'(period_q);
   assign count_rd  = 32'(count_q);
   assign irq       = pend_q && ie_q;

endmodule

// File: rtl/gptimer_multi.sv
// rtl/gptimer_multi.sv - multi-channel GP timer: address decode, read mux, interrupt OR
// Optional PWM/DUTY per channel enabled by GPTIMER_PWM_EN.
module gptimer_multi
   import gptimer_multi_pkg::*;
#(
   parameter int NUM_CHANNELS   = 4,
   parameter int WIDTH          = 32,
   parameter int PRESCALE_WIDTH = 8,
   parameter int CH_BITS        = 2
) (
   input  logic                    clk,
   input  logic                    resetq,
   input  logic                    select,
   input  logic [3:0]              wr,
   input  logic [CH_BITS+1:0]      addr,
   input  logic [31:0]             data_in,
   output logic [31:0]             data_out,
   output logic                    interrupt,
   output logic [NUM_CHANNELS-1:0] pwm_out
);

   logic               we;
   logic [CH_BITS-1:0] ch_sel;
   logic [1:0]         reg_sel;
   logic [31:0]        ctl_rd    [NUM_CHANNELS];
   logic [31:0]        period_rd [NUM_CHANNELS];
   logic [31:0]        count_rd  [NUM_CHANNELS];
   logic [31:0]        duty_rd   [NUM_CHANNELS];
   logic [NUM_CHANNELS-1:0] irq;

   assign we      = select && (wr != 4'b0000);
   assign ch_sel  = addr[CH_BITS+1:2];
   assign reg_sel = addr[1:0];

   for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
      gptimer_channel #(
         .WIDTH          (WIDTH),
         .PRESCALE_WIDTH (PRESCALE_WIDTH)
      ) u_ch (
         .clk       (clk),
         .resetq    (resetq),
         .wr_en     (we && (ch_sel == CH_BITS'(i))),
         .reg_sel   (reg_sel),
         .wr_be     (wr),
         .wdata     (data_in),
         .ctl_rd    (ctl_rd[i]),
         .period_rd (period_rd[i]),
         .count_rd  (count_rd[i]),
         .duty_rd   (duty_rd[i]),
         .irq       (irq[i]),
         .pwm       (pwm_out[i])
      );
   end

   // Addresses of unpopulated channels fall through to zero.
   always_comb begin
      data_out = '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         if (ch_sel == CH_BITS'(i)) begin
            case (reg_sel)
               REG_CTL:    data_out = ctl_rd[i];
               REG_PERIOD: data_out = period_rd[i];
               REG_COUNT:  data_out = count_rd[i];
               default:    data_out = duty_rd[i];
            endcase
         end
      end
   end

   assign interrupt = |irq;

endmodule
